flow_ctrl_fsm: RTL
==================

# flow_ctrl_fsm

Top-level flow-control state machine for the 4-in/4-out FIFO switch. It sequences the datapath through reset, configuration, idle and active phases. It holds the almost-full/almost-empty thresholds that feed every FIFO and gates the pop/push arbiter through `arb_enable`. It also watches FIFO error flags and latches which FIFO faulted, stopping traffic until reset.

## Interface
- `NUM_FIFOS`, 8, FIFOs monitored: 4 input FIFOs on bits 3:0, 4 output FIFOs on bits 7:4
- `THR_W`, 5, threshold width
- `DEPTH`, 16, FIFO depth, used for threshold validation
- `IDLE_CYCLES`, 4, consecutive all-empty cycles required to leave ACTIVE (≥1)
- `DEF_UMBRAL_ALTO`, 12, almost-full threshold after reset
- `DEF_UMBRAL_BAJO`, 2, almost-empty threshold after reset
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `init`  in  1  configuration request
- `umbral_alto_in`  in  THR_W  requested almost-full threshold
- `umbral_bajo_in`  in  THR_W  requested almost-empty threshold
- `fifo_empty`  in  NUM_FIFOS  per-FIFO empty flags
- `fifo_error`  in  NUM_FIFOS  per-FIFO error pulses (overflow/underflow)
- `umbral_alto`  out  THR_W  active almost-full threshold (registered)
- `umbral_bajo`  out  THR_W  active almost-empty threshold (registered)
- `arb_enable`  out  1  arbiter may pop/push; high only in ACTIVE
- `idle`  out  1  high only in IDLE
- `error_out`  out  NUM_FIFOS  sticky per-FIFO error record (registered)
- `cfg_err`  out  1  last config attempt was invalid (registered)
- `state`  out  3  current state encoding

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Other encodings go to RESET on the next edge.
- `reset`=1 at an edge, from any state and mid-traffic included, sets:
  - state RESET
  - umbral_alto=DEF_UMBRAL_ALTO, umbral_bajo=DEF_UMBRAL_BAJO
  - error_out=0, cfg_err=0, drain counter=0
  - therefore arb_enable=0 and idle=0
- RESET → INIT at the first edge with `reset`=0.
- Threshold valid ⇔ 1 ≤ umbral_bajo_in < umbral_alto_in ≤ DEPTH-1, compared unsigned at THR_W bits.
- INIT:
  - `init`=1 and valid: load both thresholds, cfg_err←0.
  - `init`=1 and invalid: thresholds unchanged, cfg_err←1.
  - `init`=0: go to IDLE. Thresholds are not sampled on that edge.
- IDLE:
  - Any `fifo_error` bit → ERROR (highest priority).
  - Else `init`=1 → INIT.
  - Else any `fifo_empty` bit = 0 → ACTIVE.
- ACTIVE:
  - Any `fifo_error` bit → ERROR.
  - `init` is ignored, so no reconfiguration happens under traffic.
  - Drain counter increments on each edge where all `fifo_empty` = 1, saturating at IDLE_CYCLES. Any non-empty FIFO clears it to 0.
  - Transition to IDLE on the edge where the counter would reach IDLE_CYCLES. The counter clears on entry to IDLE.
- ERROR:
  - error_out ← error_out | fifo_error on every edge in IDLE, ACTIVE and ERROR, so bits accumulate.
  - ERROR is left only through `reset`; `init` is ignored.
- `fifo_error` is ignored in RESET and INIT.
- `arb_enable`, `idle` and `state` are pure decodes of the state register, with no added latency.

## Timing
- All transitions happen at the posedge; outputs reflect the new state in the same cycle.
- Latencies:
  - Non-empty FIFO in IDLE: arb_enable=1 one cycle later.
  - Error pulse (1 cycle is enough): arb_enable=0 and error_out bit set one cycle later.
  - Config: umbral_* update one cycle after a valid `init` sample.
- Drain latency: exactly IDLE_CYCLES consecutive all-empty cycles in ACTIVE before idle=1. One non-empty cycle restarts the count.
- Simultaneous events:
  - Error beats drain-complete and beats init.
  - `reset` beats everything.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs → state=0, umbral_alto=12, umbral_bajo=2, error_out=0, arb_enable=0. Release → state=1 next edge.
- Config: in INIT drive init=1 with alto=10, bajo=3, then init=0 → umbral 10/3, cfg_err=0, state=2. Repeat with alto=3, bajo=3 → cfg_err=1, thresholds stay 10/3. Repeat with alto=16 → cfg_err=1.
- Activation and drain: in IDLE set fifo_empty=8'hFE → state=3 next cycle. All empty for 3 cycles, one non-empty cycle, then all empty for 4 cycles → state=2 exactly after the 4th.
- Errors: in ACTIVE pulse fifo_error=8'h20 → state=4, error_out=8'h20. Later pulse 8'h01 → error_out=8'h21. init=1 → still state 4. Then reset → state 0.
- Priority: in ACTIVE on the drain-completing edge also pulse fifo_error=8'h80 → state=4, not 2. In IDLE with init=1 and fifo_empty=8'hF0 → state=1.
- Reset mid-traffic: assert reset while in ACTIVE with counter=2 → state=0, arb_enable=0 that cycle, counter=0 after release.

Source files
------------

// File: rtl/flow_ctrl_if.sv
// Purpose: control/status bundle between the switch datapath and the flow-control FSM.
// Latency: wires only, no storage.
// Backpressure: none; arb_enable from the FSM gates the arbiter.
interface flow_ctrl_if #(
  parameter int NUM_FIFOS = 8,
  parameter int THR_W     = 5
);
  logic                 init;
  logic [THR_W-1:0]     umbral_alto_in;
  logic [THR_W-1:0]     umbral_bajo_in;
  logic [NUM_FIFOS-1:0] fifo_empty;
  logic [NUM_FIFOS-1:0] fifo_error;
  logic [THR_W-1:0]     umbral_alto;
  logic [THR_W-1:0]     umbral_bajo;
  logic                 arb_enable;
  logic                 idle;
  logic [NUM_FIFOS-1:0] error_out;
  logic                 cfg_err;
  logic [2:0]           state;

  // Datapath side: requests config, reports FIFO flags, consumes thresholds/enables.
  modport master (
    output init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_error,
    input  umbral_alto, umbral_bajo, arb_enable, idle, error_out, cfg_err, state
  );

  // FSM side.
  modport slave (
    input  init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_error,
    output umbral_alto, umbral_bajo, arb_enable, idle, error_out, cfg_err, state
  );
endinterface

// File: rtl/flow_ctrl_fsm.sv
// Purpose: sequences the FIFO switch through RESET/INIT/IDLE/ACTIVE/ERROR, holds thresholds, records FIFO faults.
// Latency: one cycle from input sample to new state; arb_enable/idle/state decode the state register directly.
// Backpressure: arb_enable drops in every state except ACTIVE; ERROR holds traffic off until reset.
module flow_ctrl_fsm #(
  parameter int NUM_FIFOS       = 8,
  parameter int THR_W           = 5,
  parameter int DEPTH           = 16,
  parameter int IDLE_CYCLES     = 4,
  parameter int DEF_UMBRAL_ALTO = 12,
  parameter int DEF_UMBRAL_BAJO = 2
) (
  input logic        clk,
  input logic        reset,
  flow_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int CNT_W = (IDLE_CYCLES < 2) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [THR_W-1:0] THR_MAX  = THR_W'(DEPTH - 1);
  localparam logic [THR_W-1:0] DEF_ALTO = THR_W'(DEF_UMBRAL_ALTO);
  localparam logic [THR_W-1:0] DEF_BAJO = THR_W'(DEF_UMBRAL_BAJO);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     drain_q, drain_d;
  logic [THR_W-1:0]     alto_q, alto_d;
  logic [THR_W-1:0]     bajo_q, bajo_d;
  logic [NUM_FIFOS-1:0] err_q, err_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cfg_valid;
  logic                 all_empty;
  logic                 any_error;

  // Request qualification: 1 <= bajo < alto <= DEPTH-1, all unsigned at THR_W bits.
  always_comb begin
    cfg_valid = (bus.umbral_bajo_in != '0) &&
                (bus.umbral_bajo_in < bus.umbral_alto_in) &&
                (bus.umbral_alto_in <= THR_MAX);
    all_empty = &bus.fifo_empty;
    any_error = |bus.fifo_error;
  end

  // Next-state, threshold, drain-counter and error-record logic.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    alto_d    = alto_q;
    bajo_d    = bajo_q;
    err_d     = err_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
        drain_d = '0;
      end
      ST_INIT: begin
        // Error flags are meaningless before the datapath is configured.
        drain_d = '0;
        if (bus.init) begin
          if (cfg_valid) begin
            alto_d    = bus.umbral_alto_in;
            bajo_d    = bus.umbral_bajo_in;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        drain_d = '0;
        err_d   = err_q | bus.fifo_error;
        if (any_error)       state_d = ST_ERROR;
        else if (bus.init)   state_d = ST_INIT;
        else if (!all_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // init is deliberately ignored here: no reconfiguration under traffic.
        err_d = err_q | bus.fifo_error;
        if (any_error) begin
          state_d = ST_ERROR;
          drain_d = '0;
        end else if (!all_empty) begin
          drain_d = '0;
        end else if (drain_q == CNT_LAST) begin
          state_d = ST_IDLE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        err_d   = err_q | bus.fifo_error;
        drain_d = '0;
      end
      default: begin
        state_d = ST_RESET;
        drain_d = '0;
      end
    endcase
  end

  // State and configuration registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      drain_q   <= '0;
      alto_q    <= DEF_ALTO;
      bajo_q    <= DEF_BAJO;
      err_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      alto_q    <= alto_d;
      bajo_q    <= bajo_d;
      err_q     <= err_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.umbral_alto = alto_q;
  assign bus.umbral_bajo = bajo_q;
  assign bus.error_out   = err_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.state       = state_q;
  assign bus.arb_enable  = (state_q == ST_ACTIVE);
  assign bus.idle        = (state_q == ST_IDLE);

endmodule
